// File: rtl/cpu_mem_responder_if.sv
`timescale 1ns/1ps
// Request/response bus between the CPU memory port (master) and cpu_mem_responder (slave).
// req_be is present only when CPU_MEM_BYTE_LANES_EN is defined.
interface cpu_mem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
`ifdef CPU_MEM_BYTE_LANES_EN
   logic [3:0]  req_be;
`endif
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
`ifdef CPU_MEM_BYTE_LANES_EN
      output req_be,
`endif
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
`ifdef CPU_MEM_BYTE_LANES_EN
      input  req_be,
`endif
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/cpu_mem_responder.sv
`timescale 1ns/1ps
// Word-organised RAM responder for the CPU memory port: one request at a time, READ_LAT wait states,
// misaligned/out-of-range fault flag. Define CPU_MEM_BYTE_LANES_EN for byte-enable writes via req_be.
module cpu_mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int READ_LAT    = 2
) (
   input  logic               clk,
   input  logic               reset,
   cpu_mem_responder_if.slave bus
);
   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam bit          ZERO_LAT  = (READ_LAT == 0);
   localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_LOAD = ZERO_LAT ? 4'd0 : 4'(READ_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [3:0]    cnt;
   logic [3:0]    cnt_nxt;

   logic          lat_we;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic          src_we;
   logic [31:0]   src_addr;
   logic [31:0]   src_wdata;
`ifdef CPU_MEM_BYTE_LANES_EN
   logic [3:0]    lat_be;
   logic [3:0]    src_be;
`endif

   logic [AW-1:0] idx;
   logic          fault;
   logic          accept;
   logic          commit;
   logic [31:0]   rdata_q;
   logic          err_q;

   logic [31:0]   mem [DEPTH_WORDS];

   assign accept = (state == S_IDLE) && bus.req_valid;

   // With zero wait states the commit edge is the acceptance edge, so the live bus is used directly.
   always_comb begin
      if (ZERO_LAT) begin
         src_we    = bus.req_we;
         src_addr  = bus.req_addr;
         src_wdata = bus.req_wdata;
`ifdef CPU_MEM_BYTE_LANES_EN
         src_be    = bus.req_be;
`endif
      end else begin
         src_we    = lat_we;
         src_addr  = lat_addr;
         src_wdata = lat_wdata;
`ifdef CPU_MEM_BYTE_LANES_EN
         src_be    = lat_be;
`endif
      end
   end

   assign fault = (src_addr[1:0] != 2'b00) || (src_addr[31:2] >= DEPTH_LIM);
   assign idx   = src_addr[AW+1:2];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            if (bus.req_valid) begin
               if (ZERO_LAT) begin
                  state_nxt = S_RESP;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) state_nxt = S_RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Every entry into RESP is the commit edge: write lands and read data is captured together.
   assign commit = (state != S_RESP) && (state_nxt == S_RESP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
`ifdef CPU_MEM_BYTE_LANES_EN
         lat_be    <= 4'd0;
`endif
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
`ifdef CPU_MEM_BYTE_LANES_EN
            lat_be    <= bus.req_be;
`endif
         end
         if (commit) begin
            err_q   <= fault;
            rdata_q <= (fault || src_we) ? 32'd0 : mem[idx];
         end
      end
   end

   // RAM contents survive reset; only faulting writes are suppressed.
   always_ff @(posedge clk) begin
      if (commit && src_we && !fault) begin
`ifdef CPU_MEM_BYTE_LANES_EN
         for (int i = 0; i < 4; i++) begin
            if (src_be[i]) mem[idx][8*i +: 8] <= src_wdata[8*i +: 8];
         end
`else
         mem[idx] <= src_wdata;
`endif
      end
   end

   assign bus.req_ready = (state == S_IDLE);
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
`timescale 1ns/1ps
// Bench for cpu_mem_responder: a READ_LAT=2 instance and a READ_LAT=0 instance sharing clock and reset.
module tb_cpu_mem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_mem_responder_if bus_a ();
  cpu_mem_responder_if bus_z ();

  cpu_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LAT(LAT)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  cpu_mem_responder #(.DEPTH_WORDS(DEPTH), .READ_LAT(0))   dut_z (.clk(clk), .reset(reset), .bus(bus_z));

  int checks = 0;
  int passed = 0;
  logic [31:0] model_a [DEPTH];
  logic [31:0] model_z [DEPTH];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic bit ready_of(input bit z);
    return z ? bus_z.req_ready : bus_a.req_ready;
  endfunction
  function automatic bit valid_of(input bit z);
    return z ? bus_z.rsp_valid : bus_a.rsp_valid;
  endfunction
  function automatic logic [31:0] rdata_of(input bit z);
    return z ? bus_z.rsp_rdata : bus_a.rsp_rdata;
  endfunction
  function automatic bit err_of(input bit z);
    return z ? bus_z.rsp_err : bus_a.rsp_err;
  endfunction

  task automatic drive(input bit z, input bit v, input bit we, input logic [31:0] a, input logic [31:0] wd);
    if (z) begin
      bus_z.req_valid = v; bus_z.req_we = we; bus_z.req_addr = a; bus_z.req_wdata = wd;
    end else begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = a; bus_a.req_wdata = wd;
    end
  endtask

`ifdef CPU_MEM_BYTE_LANES_EN
  task automatic set_be(input bit z, input logic [3:0] be);
    if (z) bus_z.req_be = be;
    else   bus_a.req_be = be;
  endtask
`endif

  // Reference: a word array; faults leave it untouched and return zero.
  task automatic model_apply(input bit z, input bit we, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be, output logic [31:0] rd, output bit er);
    logic [31:0] mask;
    logic [3:0]  lanes;
    int          w;
    er = (a % 4 != 0) || ((a / 4) >= DEPTH);
    rd = 32'd0;
`ifdef CPU_MEM_BYTE_LANES_EN
    lanes = be;
`else
    lanes = be | 4'hF;
`endif
    if (!er) begin
      w    = int'(a / 4);
      mask = {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
      if (we) begin
        if (z) model_z[w] = (model_z[w] & ~mask) | (wd & mask);
        else   model_a[w] = (model_a[w] & ~mask) | (wd & mask);
      end else begin
        rd = z ? model_z[w] : model_a[w];
      end
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns the sampled response.
  task automatic run_req(input bit z, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output bit er);
    int n;
    int exp_n;
    exp_n = (z ? 0 : LAT) + 1;
    n = 0;
    while (!ready_of(z) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_req", 32'(ready_of(z)), 32'd1);
    drive(z, 1'b1, we, a, wd);
`ifdef CPU_MEM_BYTE_LANES_EN
    set_be(z, be);
`endif
    @(posedge clk); #1;
    drive(z, 1'b0, ~we, ~a, ~wd);
    n = 1;
    while (!valid_of(z) && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("rsp_latency", 32'(n), 32'(exp_n));
    rd = rdata_of(z);
    er = err_of(z);
    @(posedge clk); #1;
    check("rsp_pulse_end", 32'(valid_of(z)), 32'd0);
    check("ready_after_rsp", 32'(ready_of(z)), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd, a, a2, wd;
    bit          er, exp_er, we;
    logic [3:0]  be;
    int          r;
    int          acc_cyc [$];
    logic [31:0] pend [$];

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0012, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b1};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_00FC, 32'h8000_0001, 4'hF, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 4'hF, 32'h8000_0001, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0003, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_5555, 4'hF, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 4'hF, 32'h8000_0001, 1'b0};
    vecs[10] = '{1'b1, 32'h4000_0010, 32'h0000_0077, 4'hF, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};

    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
`ifdef CPU_MEM_BYTE_LANES_EN
    set_be(1'b0, 4'hF);
    set_be(1'b1, 4'hF);
`endif
    repeat (2) @(posedge clk);
    #1;
    for (int z = 0; z < 2; z++) begin
      check("reset_ready", 32'(ready_of(z[0])), 32'd1);
      check("reset_rsp_valid", 32'(valid_of(z[0])), 32'd0);
      check("reset_rdata", rdata_of(z[0]), 32'd0);
      check("reset_err", 32'(err_of(z[0])), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) begin
      wd = 32'hA500_0001 | (32'(i) * 32'h0001_0203);
      run_req(1'b0, 1'b1, 32'(i * 4), wd, 4'hF, rd, er);
      model_apply(1'b0, 1'b1, 32'(i * 4), wd, 4'hF, exp_rd, exp_er);
      check("preload_err", 32'(er), 32'(exp_er));
    end

    foreach (vecs[i]) begin
      run_req(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er);
      model_apply(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, exp_rd, exp_er);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Valid held high: reads when ready, conflicting writes while busy (must be ignored).
    for (int c = 0; c < 24; c++) begin
      case (c % 3)
        0:       a = 32'h10;
        1:       a = 32'hFC;
        default: a = 32'h20;
      endcase
      drive(1'b0, 1'b1, !ready_of(1'b0), a, 32'h5A5A_0000 | 32'(c));
      if (ready_of(1'b0)) begin
        acc_cyc.push_back(c);
        pend.push_back(a);
      end
      @(posedge clk); #1;
      if (valid_of(1'b0)) begin
        if (pend.size() == 0) begin
          check("thru_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          a2 = pend.pop_front();
          model_apply(1'b0, 1'b0, a2, 32'd0, 4'hF, exp_rd, exp_er);
          check("thru_rdata", rdata_of(1'b0), exp_rd);
          check("thru_err", 32'(err_of(1'b0)), 32'd0);
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("thru_accept_count", 32'(acc_cyc.size()), 32'd6);
    check("thru_all_responded", 32'(pend.size()), 32'd0);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("thru_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(LAT + 2));
    run_req(1'b0, 1'b0, 32'h20, 32'd0, 4'hF, rd, er);
    model_apply(1'b0, 1'b0, 32'h20, 32'd0, 4'hF, exp_rd, exp_er);
    check("ignored_write_word8", rd, exp_rd);

    // Reset during WAIT of a write: nothing committed, outputs cleared at once.
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("midwrite_busy", 32'(ready_of(1'b0)), 32'd0);
    reset = 1'b0;
    #1;
    check("midwrite_reset_ready", 32'(ready_of(1'b0)), 32'd1);
    check("midwrite_reset_valid", 32'(valid_of(1'b0)), 32'd0);
    check("midwrite_reset_rdata", rdata_of(1'b0), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midwrite_no_rsp", 32'(valid_of(1'b0)), 32'd0);
    end
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("midwrite_no_rsp_after", 32'(valid_of(1'b0)), 32'd0);
    end
    run_req(1'b0, 1'b0, 32'h20, 32'd0, 4'hF, rd, er);
    model_apply(1'b0, 1'b0, 32'h20, 32'd0, 4'hF, exp_rd, exp_er);
    check("midwrite_old_value", rd, exp_rd);

    // Reset during an in-flight read that follows a faulting access.
    run_req(1'b0, 1'b0, 32'h100, 32'd0, 4'hF, rd, er);
    check("fault_before_reset", 32'(er), 32'd1);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    #1;
    check("midread_reset_err", 32'(err_of(1'b0)), 32'd0);
    check("midread_reset_valid", 32'(valid_of(1'b0)), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("midread_no_rsp", 32'(valid_of(1'b0)), 32'd0);
    end

    // Zero-wait-state instance.
    run_req(1'b1, 1'b1, 32'hFC, 32'hFEED_FACE, 4'hF, rd, er);
    check("z_write_err", 32'(er), 32'd0);
    run_req(1'b1, 1'b0, 32'hFC, 32'd0, 4'hF, rd, er);
    check("z_read63_rdata", rd, 32'hFEED_FACE);
    check("z_read63_err", 32'(er), 32'd0);
    run_req(1'b1, 1'b1, 32'h0, 32'h0BAD_CAFE, 4'hF, rd, er);
    run_req(1'b1, 1'b0, 32'h0, 32'd0, 4'hF, rd, er);
    check("z_read0_rdata", rd, 32'h0BAD_CAFE);
    run_req(1'b1, 1'b0, 32'h100, 32'd0, 4'hF, rd, er);
    check("z_oor_err", 32'(er), 32'd1);
    check("z_oor_rdata", rd, 32'd0);

`ifdef CPU_MEM_BYTE_LANES_EN
    run_req(1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'hF, rd, er);
    model_apply(1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'hF, exp_rd, exp_er);
    run_req(1'b0, 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, rd, er);
    model_apply(1'b0, 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, exp_rd, exp_er);
    run_req(1'b0, 1'b0, 32'h40, 32'd0, 4'b0000, rd, er);
    check("be_merge", rd, 32'h11BB_33DD);
    run_req(1'b0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, rd, er);
    check("be_none_err", 32'(er), 32'd0);
    run_req(1'b0, 1'b0, 32'h40, 32'd0, 4'hF, rd, er);
    check("be_none_unchanged", rd, 32'h11BB_33DD);
`endif

    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'($urandom_range(DEPTH, 4096)) << 2;
      else             a = $urandom();
      wd = $urandom();
      be = 4'($urandom_range(0, 15));
      run_req(1'b0, we, a, wd, be, rd, er);
      model_apply(1'b0, we, a, wd, be, exp_rd, exp_er);
      check("rand_rdata", rd, exp_rd);
      check("rand_err", 32'(er), 32'(exp_er));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
